// File: rtl/dct_8x8_2d.sv
// 8x8 2-D DCT-II (orthonormal): input register, then row pass and column pass
// of an even/odd butterfly 1-D DCT, then output register. Q16.16 in and out.

module dct_8x8_2d_1d #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 14,
  parameter int CONST_W = 16
) (
  input  logic [7:0][IN_W-1:0] x,
  output logic [7:0][IN_W-1:0] y
);
  localparam int SW = IN_W + 3;
  localparam int PW = SW + CONST_W;
  localparam int AW = PW + 2;

  localparam logic signed [CONST_W-1:0] C1 = CONST_W'(16069);
  localparam logic signed [CONST_W-1:0] C2 = CONST_W'(15137);
  localparam logic signed [CONST_W-1:0] C3 = CONST_W'(13623);
  localparam logic signed [CONST_W-1:0] C4 = CONST_W'(11585);
  localparam logic signed [CONST_W-1:0] C5 = CONST_W'(9102);
  localparam logic signed [CONST_W-1:0] C6 = CONST_W'(6270);
  localparam logic signed [CONST_W-1:0] C7 = CONST_W'(3196);

  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC - 1);
  localparam logic signed [AW-1:0] MAXV = {{(AW-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  // Full-width product, rounded to nearest, back to the sample's Q16.16 scale.
  function automatic logic signed [AW-1:0] mulr(input logic signed [SW-1:0] a,
                                                input logic signed [CONST_W-1:0] c);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(c);
    return AW'((p + RND) >>> FRAC);
  endfunction

  function automatic logic [IN_W-1:0] sat(input logic signed [AW-1:0] v);
    if (v > MAXV)      return MAXV[IN_W-1:0];
    else if (v < MINV) return MINV[IN_W-1:0];
    else               return v[IN_W-1:0];
  endfunction

  logic signed [SW-1:0] xs [8];
  logic signed [SW-1:0] s [4];
  logic signed [SW-1:0] d [4];
  logic signed [SW-1:0] a [4];
  logic signed [AW-1:0] acc [8];

  always_comb begin
    for (int i = 0; i < 8; i++) xs[i] = SW'($signed(x[i]));
    for (int i = 0; i < 4; i++) begin
      s[i] = xs[i] + xs[7-i];
      d[i] = xs[i] - xs[7-i];
    end
    a[0] = s[0] + s[3];
    a[1] = s[1] + s[2];
    a[2] = s[1] - s[2];
    a[3] = s[0] - s[3];
    acc[0] = mulr(a[0] + a[1], C4);
    acc[4] = mulr(a[0] - a[1], C4);
    acc[2] = mulr(a[3], C2) + mulr(a[2], C6);
    acc[6] = mulr(a[3], C6) - mulr(a[2], C2);
    acc[1] = mulr(d[0], C1) + mulr(d[1], C3) + mulr(d[2], C5) + mulr(d[3], C7);
    acc[3] = mulr(d[0], C3) - mulr(d[1], C7) - mulr(d[2], C1) - mulr(d[3], C5);
    acc[5] = mulr(d[0], C5) - mulr(d[1], C1) + mulr(d[2], C7) + mulr(d[3], C3);
    acc[7] = mulr(d[0], C7) - mulr(d[1], C5) + mulr(d[2], C3) - mulr(d[3], C1);
    // The C(k)/2 factor is the exact >>>1; C(0)=1/sqrt2 rides in C4.
    for (int k = 0; k < 8; k++) y[k] = sat(acc[k] >>> 1);
  end
endmodule

module dct_8x8_2d #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 14,
  parameter int CONST_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [64*IN_W-1:0]   din_flat,
  output logic                 out_valid,
  output logic [64*IN_W-1:0]   dout_flat
);
  logic [63:0][IN_W-1:0]     din_d, din_q, dout_d, dout_q;
  logic [1:0]                vld_pipe_d, vld_pipe_q;
  logic [7:0][7:0][IN_W-1:0] row_res, col_in, col_out;

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_row
      dct_8x8_2d_1d #(.IN_W(IN_W), .FRAC(FRAC), .CONST_W(CONST_W)) u_row (
        .x(din_q[g*8 +: 8]),
        .y(row_res[g])
      );
    end
    for (g = 0; g < 8; g++) begin : g_col
      dct_8x8_2d_1d #(.IN_W(IN_W), .FRAC(FRAC), .CONST_W(CONST_W)) u_col (
        .x(col_in[g]),
        .y(col_out[g])
      );
    end
  endgenerate

  // col_in[c][r] is row result (r,c); col_out[v][u] lands at coefficient (u,v).
  always_comb begin
    din_d      = din_flat;
    vld_pipe_d = {vld_pipe_q[0], in_valid};
    col_in     = '0;
    dout_d     = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        col_in[c][r]   = row_res[r][c];
        dout_d[r*8+c]  = col_out[c][r];
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q      <= '0;
      dout_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      din_q      <= din_d;
      dout_q     <= dout_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign dout_flat = dout_q;
  assign out_valid = vld_pipe_q[1];
endmodule

// File: tb/tb_dct_8x8_2d.sv
// Scoreboard bench for dct_8x8_2d: a double-precision 2-D DCT model fills an
// expected-block queue at issue time; a negedge monitor pops and compares.
module tb_dct_8x8_2d;
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [2047:0] din_flat;
  logic          out_valid;
  logic [2047:0] dout_flat;

  int pos_cnt   = 0;
  int checks    = 0;
  int errors    = 0;
  int valid_cnt = 0;

  longint exp_q[$];
  int     due_q[$];
  bit     exact_q[$];
  longint ref_blk[64];

  always #5 clk = ~clk;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  dct_8x8_2d #(.IN_W(32), .FRAC(14), .CONST_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_flat(din_flat),
    .out_valid(out_valid), .dout_flat(dout_flat)
  );

  task automatic model(input logic [2047:0] blk);
    real x[8][8];
    real acc, cu, cv;
    real pi;
    int  xi;
    pi = 3.14159265358979323846;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        xi = blk[(r*8+c)*32 +: 32];
        x[r][c] = real'(xi) / 65536.0;
      end
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        acc = 0.0;
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            acc += x[r][c] * $cos((2*r+1)*u*pi/16.0) * $cos((2*c+1)*v*pi/16.0);
        cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        acc = 0.25 * cu * cv * acc * 65536.0;
        if (acc > 2147483647.0)  acc = 2147483647.0;
        if (acc < -2147483648.0) acc = -2147483648.0;
        ref_blk[u*8+v] = longint'(acc);
      end
  endtask

  task automatic send(input logic [2047:0] blk, input bit exact);
    model(blk);
    @(posedge clk); #1;
    din_flat = blk;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) exp_q.push_back(ref_blk[i]);
    due_q.push_back(pos_cnt + 2);
    exact_q.push_back(exact);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      din_flat = '0;
    end
  endtask

  function automatic logic [2047:0] fill(input int v);
    logic [2047:0] b;
    for (int i = 0; i < 64; i++) b[i*32 +: 32] = v;
    return b;
  endfunction

  function automatic logic [2047:0] rand_blk();
    logic [2047:0] b;
    for (int i = 0; i < 64; i++)
      b[i*32 +: 32] = int'($urandom_range(0, 510*65536)) - 255*65536;
    return b;
  endfunction

  // Monitor
  always @(negedge clk) begin
    int     due, bad, ai;
    bit     ex;
    longint e, a, diff, e_bad, a_bad;
    if (out_valid === 1'b1) begin
      valid_cnt++;
      checks++;
      if (due_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block: out_valid=1 at edge %0d, required no output", pos_cnt);
      end else begin
        due = due_q.pop_front();
        ex  = exact_q.pop_front();
        bad = -1; e_bad = 0; a_bad = 0;
        for (int i = 0; i < 64; i++) begin
          e  = exp_q.pop_front();
          ai = dout_flat[i*32 +: 32];
          a  = longint'(ai);
          diff = (a > e) ? a - e : e - a;
          if (bad < 0 && (ex ? (diff != 0) : (diff > 64'sd32768))) begin
            bad = i; e_bad = e; a_bad = a;
          end
        end
        if (bad >= 0) begin
          errors++;
          $display("FAIL block_coef: coef (%0d,%0d) got %0d required %0d (exact=%0d)",
                   bad / 8, bad % 8, a_bad, e_bad, ex);
        end else if (pos_cnt != due) begin
          errors++;
          $display("FAIL block_latency: arrived after edge %0d, required edge %0d", pos_cnt, due);
        end
      end
    end
  end

  initial begin
    logic [2047:0] b;
    int v0;
    rst = 1'b1; in_valid = 1'b0; din_flat = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    checks++;
    if (dout_flat !== '0) begin errors++; $display("FAIL reset_data: got nonzero required 0"); end
    #1 rst = 1'b0;

    send('0, 1'b1);
    send(fill(32'h00010000), 1'b0);
    send(fill(32'hFFFF0000), 1'b0);
    b = '0; b[31:0] = 32'h00400000;
    send(b, 1'b0);
    send(fill(32'h7FFFFFFF), 1'b0);
    send(fill(32'h80000000), 1'b0);
    idle(3);
    send(rand_blk(), 1'b0);
    idle(2);
    send(rand_blk(), 1'b0);
    idle(4);

    v0 = valid_cnt;
    for (int k = 0; k < 100; k++) send(rand_blk(), 1'b0);
    idle(4);
    checks++;
    if (valid_cnt - v0 != 100) begin
      errors++;
      $display("FAIL burst_valid_count: got %0d cycles required 100", valid_cnt - v0);
    end

    // Two blocks in flight, then an asynchronous mid-cycle reset.
    send(rand_blk(), 1'b0);
    send(rand_blk(), 1'b0);
    @(posedge clk); #3;
    rst = 1'b1; in_valid = 1'b0; din_flat = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", out_valid); end
    checks++;
    if (dout_flat !== '0) begin errors++; $display("FAIL midreset_data: got nonzero required 0"); end
    exp_q.delete(); due_q.delete(); exact_q.delete();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    send(fill(32'h00010000), 1'b0);
    idle(5);

    checks++;
    if (due_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d blocks never emerged, required 0", due_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
